// File: rtl/mux_pkg.sv
// mux_pkg -- shared definitions for the scanning N:1 multiplexer.
// Holds the MANUAL/SCAN state encodings and the width helpers used to
// size the channel select from the channel count.
package mux_pkg;

  // Operating mode doubles as the FSM state: the state register simply
  // follows the mode input, so the encodings match the mode pin.
  typedef enum logic {
    MANUAL = 1'b0,
    SCAN   = 1'b1
  } state_t;

  // Width of the dwell counter; large enough for DWELL up to 255.
  localparam int CNT_W = 8;

  // Ceiling log2, usable in constant expressions.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  // Select width never drops below one bit, even for tiny channel counts.
  function automatic int sel_width(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/mux_nx1.sv
// mux_nx1 -- purely combinational N:1 channel selector.
// Ports:
//   data_in  N*W  packed channels, channel k at bits [k*W+W-1 : k*W]
//   sel      SW   channel index
//   y        W    selected channel, all zeros when sel >= N
module mux_nx1
  import mux_pkg::*;
#(
  parameter int N = 5,
  parameter int W = 1,
  localparam int SW = sel_width(N)
) (
  input  logic [N*W-1:0] data_in,
  input  logic [SW-1:0]  sel,
  output logic [W-1:0]   y
);

  // Indices that match no channel fall through to the zero default, which
  // is how out-of-range selects produce an all-zero result.
  always_comb begin
    y = '0;
    for (int k = 0; k < N; k++) begin
      if (sel == SW'(k)) begin
        y = data_in[k*W +: W];
      end
    end
  end

endmodule

// File: rtl/mux_scan_nx1.sv
// mux_scan_nx1 -- registered N:1 multiplexer with manual and scan modes.
// In MANUAL the channel register is loaded from sel on demand (any index).
// In SCAN the channel register steps through 0..N-1, dwelling DWELL cycles
// on each channel; out-of-range loads are refused and flagged.
// Ports:
//   clk      1     rising-edge clock
//   reset    1     synchronous active-high reset
//   data_in  N*W   packed channels
//   sel      SW    requested channel index
//   load     1     capture sel into the channel register
//   mode     1     0 = MANUAL, 1 = SCAN
//   out      W     registered data of the current channel (1-cycle latency)
//   cur_sel  SW    current channel register
//   invalid  1     cur_sel holds an index >= N
//   wrap     1     pulse when scanning wraps from N-1 to 0
//   rej      1     pulse when a load is refused in SCAN
module mux_scan_nx1
  import mux_pkg::*;
#(
  parameter int N     = 5,
  parameter int W     = 1,
  parameter int DWELL = 4,
  localparam int SW   = sel_width(N)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N*W-1:0] data_in,
  input  logic [SW-1:0]  sel,
  input  logic           load,
  input  logic           mode,
  output logic [W-1:0]   out,
  output logic [SW-1:0]  cur_sel,
  output logic           invalid,
  output logic           wrap,
  output logic           rej
);

  state_t           state;
  state_t           state_next;
  logic [SW-1:0]    sel_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             wrap_next;
  logic             rej_next;
  logic [W-1:0]     mux_y;
  logic             sel_valid;
  logic             cur_last;
  logic             cnt_last;

  mux_nx1 #(
    .N (N),
    .W (W)
  ) u_mux (
    .data_in (data_in),
    .sel     (cur_sel),
    .y       (mux_y)
  );

  assign invalid   = (int'(cur_sel) >= N);
  assign sel_valid = (int'(sel) < N);
  assign cur_last  = (int'(cur_sel) == N - 1);
  assign cnt_last  = (cnt == CNT_W'(DWELL - 1));

  // Next-state logic. Mode changes are handled from the current state so
  // the edge that enters or leaves SCAN can clean up the counter and any
  // out-of-range channel before scanning starts; loads are ignored on
  // those transition edges.
  always_comb begin
    state_next = state_t'(mode);
    sel_next   = cur_sel;
    cnt_next   = cnt;
    wrap_next  = 1'b0;
    rej_next   = 1'b0;
    case (state)
      MANUAL: begin
        cnt_next = '0;
        if (mode) begin
          if (invalid) begin
            sel_next = '0;
          end
        end else if (load) begin
          sel_next = sel;
        end
      end
      SCAN: begin
        if (!mode) begin
          cnt_next = '0;
        end else if (load && sel_valid) begin
          sel_next = sel;
          cnt_next = '0;
        end else if (load) begin
          rej_next = 1'b1;
        end else if (cnt_last) begin
          cnt_next = '0;
          if (cur_last) begin
            sel_next  = '0;
            wrap_next = 1'b1;
          end else begin
            sel_next = cur_sel + 1'b1;
          end
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      default: begin
        cnt_next = '0;
      end
    endcase
  end

  // State, channel, counter, pulses and the output data register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= MANUAL;
      cur_sel <= '0;
      cnt     <= '0;
      out     <= '0;
      wrap    <= 1'b0;
      rej     <= 1'b0;
    end else begin
      state   <= state_next;
      cur_sel <= sel_next;
      cnt     <= cnt_next;
      out     <= mux_y;
      wrap    <= wrap_next;
      rej     <= rej_next;
    end
  end

endmodule

// File: tb/tb_mux_scan_nx1.sv
// tb_mux_scan_nx1 -- directed self-checking bench for mux_scan_nx1.
// Two instances: the default configuration (N=5, W=1, DWELL=4) and a
// byte-wide, three-channel, single-cycle-dwell configuration.
module tb_mux_scan_nx1;

  logic        clk;
  logic        reset;
  logic [4:0]  data_in;
  logic [2:0]  sel;
  logic        load;
  logic        mode;
  logic [0:0]  out;
  logic [2:0]  cur_sel;
  logic        invalid;
  logic        wrap;
  logic        rej;

  logic        reset8;
  logic [23:0] data_in8;
  logic [1:0]  sel8;
  logic        load8;
  logic        mode8;
  logic [7:0]  out8;
  logic [1:0]  cur_sel8;
  logic        invalid8;
  logic        wrap8;
  logic        rej8;

  int passed;
  int total;

  mux_scan_nx1 dut (
    .clk     (clk),
    .reset   (reset),
    .data_in (data_in),
    .sel     (sel),
    .load    (load),
    .mode    (mode),
    .out     (out),
    .cur_sel (cur_sel),
    .invalid (invalid),
    .wrap    (wrap),
    .rej     (rej)
  );

  mux_scan_nx1 #(
    .N     (3),
    .W     (8),
    .DWELL (1)
  ) dut8 (
    .clk     (clk),
    .reset   (reset8),
    .data_in (data_in8),
    .sel     (sel8),
    .load    (load8),
    .mode    (mode8),
    .out     (out8),
    .cur_sel (cur_sel8),
    .invalid (invalid8),
    .wrap    (wrap8),
    .rej     (rej8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Wait for the next rising edge, then settle just past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive the default instance's control inputs and run one clock.
  task automatic applyStimulus(input logic ld, input logic [2:0] s, input logic md);
    load = ld;
    sel  = s;
    mode = md;
    tick();
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected) passed++;
    else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
  endtask

  initial begin
    passed   = 0;
    total    = 0;
    reset    = 1'b1;
    load     = 1'b1;
    sel      = 3'd3;
    mode     = 1'b1;
    data_in  = 5'b11111;
    reset8   = 1'b1;
    load8    = 1'b0;
    sel8     = 2'd0;
    mode8    = 1'b0;
    data_in8 = {8'h0F, 8'h55, 8'hAA};
    tick();
    tick();

    // Reset wins over load and mode.
    checkOutput("rst_out",     32'(out),     32'd0);
    checkOutput("rst_cur_sel", 32'(cur_sel), 32'd0);
    checkOutput("rst_invalid", 32'(invalid), 32'd0);
    checkOutput("rst_wrap",    32'(wrap),    32'd0);
    checkOutput("rst_rej",     32'(rej),     32'd0);
    checkOutput("rst_out8",    32'(out8),    32'd0);

    reset  = 1'b0;
    reset8 = 1'b0;
    applyStimulus(1'b0, 3'd0, 1'b0);

    // MANUAL: a single hot channel follows the selected index.
    for (int k = 0; k < 5; k++) begin
      data_in = 5'(1 << k);
      applyStimulus(1'b1, 3'(k), 1'b0);
      checkOutput($sformatf("man_cur_sel_%0d", k), 32'(cur_sel), 32'(k));
      applyStimulus(1'b0, 3'(k), 1'b0);
      checkOutput($sformatf("man_out_%0d", k), 32'(out), 32'd1);
      checkOutput($sformatf("man_wrap_%0d", k), 32'(wrap), 32'd0);
    end

    // MANUAL: out-of-range indices are accepted and give zero data.
    data_in = 5'b11111;
    for (int s = 5; s < 8; s++) begin
      applyStimulus(1'b1, 3'(s), 1'b0);
      checkOutput($sformatf("oor_cur_sel_%0d", s), 32'(cur_sel), 32'(s));
      checkOutput($sformatf("oor_invalid_%0d", s), 32'(invalid), 32'd1);
      applyStimulus(1'b0, 3'(s), 1'b0);
      checkOutput($sformatf("oor_out_%0d", s), 32'(out), 32'd0);
      checkOutput($sformatf("oor_rej_%0d", s), 32'(rej), 32'd0);
    end

    // Entering SCAN with an invalid channel snaps it to 0.
    applyStimulus(1'b0, 3'd0, 1'b1);
    checkOutput("enter_cur_sel", 32'(cur_sel), 32'd0);
    checkOutput("enter_invalid", 32'(invalid), 32'd0);

    // SCAN: four cycles per channel, wrap pulse on the 4->0 edge only.
    for (int i = 1; i <= 20; i++) begin
      applyStimulus(1'b0, 3'd0, 1'b1);
      checkOutput($sformatf("scan_cur_sel_%0d", i), 32'(cur_sel), 32'((i / 4) % 5));
      checkOutput($sformatf("scan_wrap_%0d", i), 32'(wrap), (i == 20) ? 32'd1 : 32'd0);
      checkOutput($sformatf("scan_out_%0d", i), 32'(out), 32'd1);
    end

    // Counter is now 0 on channel 0; bring it to its last dwell cycle.
    applyStimulus(1'b0, 3'd0, 1'b1);
    applyStimulus(1'b0, 3'd0, 1'b1);
    applyStimulus(1'b0, 3'd0, 1'b1);
    // A valid load beats the pending advance and restarts the dwell.
    applyStimulus(1'b1, 3'd2, 1'b1);
    checkOutput("prio_cur_sel", 32'(cur_sel), 32'd2);
    applyStimulus(1'b0, 3'd0, 1'b1);
    applyStimulus(1'b0, 3'd0, 1'b1);
    applyStimulus(1'b0, 3'd0, 1'b1);
    checkOutput("prio_hold", 32'(cur_sel), 32'd2);
    applyStimulus(1'b0, 3'd0, 1'b1);
    checkOutput("prio_adv", 32'(cur_sel), 32'd3);

    // Out-of-range load in SCAN is refused; channel and counter frozen.
    applyStimulus(1'b1, 3'd6, 1'b1);
    checkOutput("rej_pulse",   32'(rej),     32'd1);
    checkOutput("rej_cur_sel", 32'(cur_sel), 32'd3);
    applyStimulus(1'b0, 3'd0, 1'b1);
    checkOutput("rej_clear", 32'(rej), 32'd0);
    applyStimulus(1'b0, 3'd0, 1'b1);
    applyStimulus(1'b0, 3'd0, 1'b1);
    checkOutput("rej_hold", 32'(cur_sel), 32'd3);
    applyStimulus(1'b0, 3'd0, 1'b1);
    checkOutput("rej_adv", 32'(cur_sel), 32'd4);

    // Back to MANUAL: channel holds, then a manual load takes effect.
    applyStimulus(1'b0, 3'd0, 1'b0);
    checkOutput("exit_cur_sel", 32'(cur_sel), 32'd4);
    applyStimulus(1'b1, 3'd1, 1'b0);
    checkOutput("man_load", 32'(cur_sel), 32'd1);

    // Re-enter SCAN from a valid channel: dwell restarts from zero.
    applyStimulus(1'b0, 3'd0, 1'b1);
    checkOutput("reenter_cur_sel", 32'(cur_sel), 32'd1);
    applyStimulus(1'b0, 3'd0, 1'b1);
    applyStimulus(1'b0, 3'd0, 1'b1);
    applyStimulus(1'b0, 3'd0, 1'b1);
    checkOutput("reenter_hold", 32'(cur_sel), 32'd1);
    applyStimulus(1'b0, 3'd0, 1'b1);
    checkOutput("reenter_adv", 32'(cur_sel), 32'd2);

    // Byte-wide instance, DWELL=1: advances every cycle in SCAN.
    mode8 = 1'b1;
    tick();
    checkOutput("w8_a_cur_sel", 32'(cur_sel8), 32'd0);
    checkOutput("w8_a_out",     32'(out8),     32'hAA);
    tick();
    checkOutput("w8_b_cur_sel", 32'(cur_sel8), 32'd1);
    checkOutput("w8_b_out",     32'(out8),     32'hAA);
    tick();
    checkOutput("w8_c_cur_sel", 32'(cur_sel8), 32'd2);
    checkOutput("w8_c_out",     32'(out8),     32'h55);
    tick();
    checkOutput("w8_d_cur_sel", 32'(cur_sel8), 32'd0);
    checkOutput("w8_d_out",     32'(out8),     32'h0F);
    checkOutput("w8_d_wrap",    32'(wrap8),    32'd1);
    tick();
    checkOutput("w8_e_cur_sel", 32'(cur_sel8), 32'd1);
    checkOutput("w8_e_out",     32'(out8),     32'hAA);
    checkOutput("w8_e_wrap",    32'(wrap8),    32'd0);
    tick();
    checkOutput("w8_f_out",     32'(out8),     32'h55);

    // Reset on the edge that would otherwise wrap: no pulse, all zero.
    reset8 = 1'b1;
    tick();
    checkOutput("w8_rst_out",     32'(out8),     32'd0);
    checkOutput("w8_rst_cur_sel", 32'(cur_sel8), 32'd0);
    checkOutput("w8_rst_wrap",    32'(wrap8),    32'd0);
    checkOutput("w8_rst_rej",     32'(rej8),     32'd0);
    checkOutput("w8_rst_invalid", 32'(invalid8), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mux_scan_nx1.md
MUX_SCAN_NX1 -- requirements
Module: mux_scan_nx1

Interface
REQ-001 Parameter: N, default 5, number of input channels (2..16).
REQ-002 Parameter: W, default 1, channel data width in bits (1..32).
REQ-003 Parameter: DWELL, default 4, cycles spent on each channel in scan mode (1..255).
REQ-004 Derived constant: SW = max(1, ceil(log2(N))), select width.
REQ-005 One clock; reset is synchronous and active-high.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 reset  input  1  synchronous active-high reset.
REQ-008 data_in  input  N*W  packed channels; channel k occupies bits [k*W+W-1 : k*W].
REQ-009 sel  input  SW  requested channel index.
REQ-010 load  input  1  capture sel into the channel register this cycle.
REQ-011 mode  input  1  0 = MANUAL, 1 = SCAN.
REQ-012 out  output  W  registered selected channel data.
REQ-013 cur_sel  output  SW  current channel register.
REQ-014 invalid  output  1  level; cur_sel holds an index >= N.
REQ-015 wrap  output  1  one-cycle pulse when scan advances from N-1 to 0.
REQ-016 rej  output  1  one-cycle pulse when a load is rejected in SCAN.

Function
REQ-017 The FSM SHALL have two states, MANUAL and SCAN; the state register takes the value of mode every cycle.
REQ-018 out SHALL update every cycle: out(t+1) = channel cur_sel(t) of data_in(t); the latency from cur_sel to out is 1 cycle.
REQ-019 When cur_sel >= N, out SHALL be driven to all zeros on the next cycle, and invalid SHALL be 1.
REQ-020 In MANUAL, load=1 SHALL set cur_sel <= sel unconditionally, including indices >= N.
REQ-021 In MANUAL, the dwell counter SHALL hold at 0, and wrap and rej SHALL be 0.
REQ-022 In SCAN, the dwell counter SHALL count 0..DWELL-1; at DWELL-1 it SHALL return to 0 and cur_sel SHALL advance by 1.
REQ-023 In SCAN, an advance from N-1 SHALL go to 0 and pulse wrap in the same cycle the register updates.
REQ-024 In SCAN, load=1 with sel < N SHALL set cur_sel <= sel and clear the counter, and SHALL take priority over an advance in the same cycle.
REQ-025 In SCAN, load=1 with sel >= N SHALL be rejected: rej pulses, cur_sel and the counter are unchanged.
REQ-026 On the MANUAL->SCAN transition, the counter SHALL clear; if cur_sel >= N, cur_sel SHALL become 0 on that edge.
REQ-027 On the SCAN->MANUAL transition, cur_sel SHALL hold its value and the counter SHALL clear.
REQ-028 With DWELL=1, cur_sel SHALL advance every cycle in SCAN.

Reset
REQ-029 When reset=1 on a rising edge, out=0, cur_sel=0, invalid=0, wrap=0, rej=0, counter=0 and state=MANUAL, overriding load and mode.
REQ-030 Reset asserted mid-scan SHALL abort the dwell, and no wrap or rej pulse SHALL be produced on that edge.

Structure
REQ-031 Shared package mux_pkg SHALL hold the MANUAL/SCAN encodings and the clog2 helper used to derive SW.
REQ-032 The combinational selection SHALL be one sub-module mux_nx1 (parameters N, W) that outputs zero for an index >= N; mux_scan_nx1 instantiates it once and registers its output.

Verification
REQ-033 Defaults, MANUAL, data_in channels = 1,0,0,0,0 in turn, load sel=0..4 -> out=1 one cycle after each cur_sel update.
REQ-034 MANUAL, all channels = 1, load sel=5,6,7 -> invalid=1, out=0 next cycle; then switch to SCAN -> cur_sel=0, invalid=0.
REQ-035 SCAN, DWELL=4, N=5 -> cur_sel steps 0,1,2,3,4,0 every 4 cycles; wrap is high exactly 1 cycle at the 4->0 edge.
REQ-036 SCAN, load sel=2 on the same cycle as an advance -> cur_sel=2, counter=0; load sel=6 -> rej pulse, cur_sel unchanged.
REQ-037 W=8, N=3, DWELL=1, data_in = 0xAA,0x55,0x0F -> out cycles 0xAA,0x55,0x0F with 1-cycle latency; reset mid-scan -> all outputs 0 next cycle.
